// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and dmem_responder.
// Initiator owns req_valid/req_*/rsp_ready; responder owns req_ready/rsp_*.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and byte-lane writes.
// Optional macro DMEM_RESP_ERR_EN flags misaligned / out-of-range accesses instead of wrapping.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = DW / 8;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic              write_q, write_d;
  logic              acc_err_q, acc_err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DW-1:0]     mem_q [DEPTH_WORDS];
  logic              mem_we_c;
  logic [DW-1:0]     rd_word_c;
  logic [DW-1:0]     wr_word_c;
  logic              addr_err_c;

  // Address legality is judged on the live request and latched at acceptance.
`ifdef DMEM_RESP_ERR_EN
  assign addr_err_c = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[DW-1:AW+2] != '0);
`else
  logic unused_addr_bits_c;
  assign addr_err_c         = 1'b0;
  assign unused_addr_bits_c = ^{bus.req_addr[DW-1:AW+2], bus.req_addr[1:0]};
`endif

  assign rd_word_c = mem_q[idx_q];

  // Read-modify-write merge: only enabled lanes take the new data.
  always_comb begin
    wr_word_c = rd_word_c;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be_q[b]) begin
        wr_word_c[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    write_d     = write_q;
    acc_err_d   = acc_err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          idx_d       = bus.req_addr[AW+1:2];
          wdata_d     = bus.req_wdata;
          be_d        = bus.req_be;
          write_d     = bus.req_write;
          acc_err_d   = addr_err_c;
          cnt_d       = CNT_LOAD;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end

      // Commit and read capture share the WAIT->RESP edge, so a following
      // request always observes the committed word.
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err_q;
          rsp_rdata_d = (write_q || acc_err_q) ? '0 : rd_word_c;
          mem_we_c    = write_q && !acc_err_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      acc_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      write_q     <= write_d;
      acc_err_q   <= acc_err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage clears on reset; an aborted write never reached mem_we_c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[idx_q] <= wr_word_c;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
